// File: rtl/operand_requester_slot.sv
// ---------------------------------------------------------------------------
// operand_requester_slot
//
// Turns one operand read request (source vreg, word count, id) into a stream
// of per-word VRF reads for a single lane. Each granted read becomes one word
// pushed into the destination operand queue. A command carrying the word count
// is pushed to the queue when the request is accepted.
//
// Handshakes:
//   req_valid_i/req_ready_o : a request transfers in any cycle where both are
//     high. req_ready_o is high in IDLE, and also in the cycle that issues the
//     last word, so a new request can follow with no bubble.
//   vrf_req_o/vrf_gnt_i     : a read issues in any cycle where both are high.
//     A grant with no request is ignored.
//
// Ports:
//   clk_i, rst_ni                 clock, async active-low reset
//   req_valid_i, req_ready_o      request handshake
//   req_vs_i, req_len_i, req_id_i request fields (vreg, word count, id)
//   stall_i                       scoreboard hazard (used only with the macro)
//   vrf_req_o, vrf_addr_o, vrf_gnt_i  VRF read port
//   operand_queue_ready_i         queue has room for one word
//   operand_issued_o              one word issued this cycle
//   operand_queue_cmd_valid_o/_len_o  command push to the queue
//   done_o, done_id_o             one-cycle completion pulse with id
//
// Configuration macro: OPREQ_HAZARD_STALL_EN
//   defined   : stall_i gates vrf_req_o
//   undefined : stall_i is ignored
// ---------------------------------------------------------------------------
module operand_requester_slot #(
    parameter int unsigned NrLanes = 4,
    parameter int unsigned VLEN    = 4096
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic [4:0]            req_vs_i,
    input  logic [15:0]           req_len_i,
    input  logic [2:0]            req_id_i,
    input  logic                  stall_i,
    output logic                  vrf_req_o,
    output logic [$clog2(32*(VLEN/NrLanes/64))-1:0] vrf_addr_o,
    input  logic                  vrf_gnt_i,
    input  logic                  operand_queue_ready_i,
    output logic                  operand_issued_o,
    output logic                  operand_queue_cmd_valid_o,
    output logic [15:0]           operand_queue_cmd_len_o,
    output logic                  done_o,
    output logic [2:0]            done_id_o
);

    localparam int unsigned VRegWords = VLEN / NrLanes / 64;
    localparam int unsigned AddrW     = $clog2(32 * VRegWords);

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  vs_q, vs_d;
    logic [15:0] len_q, len_d;
    logic [2:0]  id_q, id_d;
    logic [15:0] cnt_q, cnt_d;
    // Zero-length requests complete one cycle after acceptance.
    logic        zdone_q, zdone_d;
    logic [2:0]  zdone_id_q, zdone_id_d;

    logic in_issue;
    logic issue;
    logic last;
    logic accept;

`ifndef OPREQ_HAZARD_STALL_EN
    logic unused_stall;
    assign unused_stall = stall_i;
`endif

    always_comb begin
        state_d    = state_q;
        vs_d       = vs_q;
        len_d      = len_q;
        id_d       = id_q;
        cnt_d      = cnt_q;
        zdone_d    = 1'b0;
        zdone_id_d = '0;

        in_issue = (state_q == ISSUE);
`ifdef OPREQ_HAZARD_STALL_EN
        vrf_req_o = in_issue & operand_queue_ready_i & ~stall_i;
`else
        vrf_req_o = in_issue & operand_queue_ready_i;
`endif
        issue = vrf_req_o & vrf_gnt_i;
        last  = issue & (cnt_q == len_q - 16'd1);

        req_ready_o = ~in_issue | last;
        accept      = req_valid_i & req_ready_o;

        // Address wraps naturally by truncation to AddrW bits.
        vrf_addr_o = in_issue ? (AddrW'(vs_q) * AddrW'(VRegWords) + AddrW'(cnt_q)) : '0;

        operand_issued_o          = issue;
        operand_queue_cmd_valid_o = accept & (req_len_i != 16'd0);
        operand_queue_cmd_len_o   = operand_queue_cmd_valid_o ? req_len_i : 16'd0;

        done_o    = last | zdone_q;
        done_id_o = last ? id_q : (zdone_q ? zdone_id_q : 3'd0);

        if (issue) begin
            cnt_d = cnt_q + 16'd1;
        end
        if (last) begin
            state_d = IDLE;
        end
        if (accept && (req_len_i == 16'd0)) begin
            zdone_d    = 1'b1;
            zdone_id_d = req_id_i;
        end
        // A new request (possibly in the last-grant cycle) overrides the
        // return to IDLE and restarts the word counter.
        if (operand_queue_cmd_valid_o) begin
            state_d = ISSUE;
            vs_d    = req_vs_i;
            len_d   = req_len_i;
            id_d    = req_id_i;
            cnt_d   = 16'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            vs_q       <= '0;
            len_q      <= '0;
            id_q       <= '0;
            cnt_q      <= '0;
            zdone_q    <= 1'b0;
            zdone_id_q <= '0;
        end else begin
            state_q    <= state_d;
            vs_q       <= vs_d;
            len_q      <= len_d;
            id_q       <= id_d;
            cnt_q      <= cnt_d;
            zdone_q    <= zdone_d;
            zdone_id_q <= zdone_id_d;
        end
    end

endmodule

// File: tb/tb_operand_requester_slot.sv
// Directed bench for operand_requester_slot (NrLanes=4, VLEN=4096 -> AddrW=9).
module tb_operand_requester_slot;

  localparam int ADDR_W = 9;
`ifdef OPREQ_HAZARD_STALL_EN
  localparam bit STALL_EN = 1'b1;
`else
  localparam bit STALL_EN = 1'b0;
`endif

  // clock/reset block
  logic clk_i = 1'b0;
  logic rst_ni;
  always #5 clk_i = ~clk_i;

  logic              req_valid_i;
  logic              req_ready_o;
  logic [4:0]        req_vs_i;
  logic [15:0]       req_len_i;
  logic [2:0]        req_id_i;
  logic              stall_i;
  logic              vrf_req_o;
  logic [ADDR_W-1:0] vrf_addr_o;
  logic              vrf_gnt_i;
  logic              operand_queue_ready_i;
  logic              operand_issued_o;
  logic              operand_queue_cmd_valid_o;
  logic [15:0]       operand_queue_cmd_len_o;
  logic              done_o;
  logic [2:0]        done_id_o;

  operand_requester_slot #(.NrLanes(4), .VLEN(4096)) dut (
    .clk_i                     (clk_i),
    .rst_ni                    (rst_ni),
    .req_valid_i               (req_valid_i),
    .req_ready_o               (req_ready_o),
    .req_vs_i                  (req_vs_i),
    .req_len_i                 (req_len_i),
    .req_id_i                  (req_id_i),
    .stall_i                   (stall_i),
    .vrf_req_o                 (vrf_req_o),
    .vrf_addr_o                (vrf_addr_o),
    .vrf_gnt_i                 (vrf_gnt_i),
    .operand_queue_ready_i     (operand_queue_ready_i),
    .operand_issued_o          (operand_issued_o),
    .operand_queue_cmd_valid_o (operand_queue_cmd_valid_o),
    .operand_queue_cmd_len_o   (operand_queue_cmd_len_o),
    .done_o                    (done_o),
    .done_id_o                 (done_id_o)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive phase starts 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic present(input logic [4:0] vs, input logic [15:0] len, input logic [2:0] id);
    req_valid_i = 1'b1;
    req_vs_i    = vs;
    req_len_i   = len;
    req_id_i    = id;
  endtask

  task automatic idle_req();
    req_valid_i = 1'b0;
    req_vs_i    = '0;
    req_len_i   = '0;
    req_id_i    = '0;
  endtask

  // Checks one issuing cycle: read at addr, done with id only when is_last.
  task automatic check_issue(input string tag, input int addr, input bit is_last, input int id);
    check({tag, "_req"},    32'(vrf_req_o), 1);
    check({tag, "_addr"},   32'(vrf_addr_o), 32'(addr));
    check({tag, "_issued"}, 32'(operand_issued_o), 1);
    check({tag, "_ready"},  32'(req_ready_o), 32'(is_last));
    check({tag, "_done"},   32'(done_o), 32'(is_last));
    if (is_last) check({tag, "_done_id"}, 32'(done_id_o), 32'(id));
  endtask

  task automatic check_all_quiet(input string tag);
    check({tag, "_ready"},   32'(req_ready_o), 1);
    check({tag, "_req"},     32'(vrf_req_o), 0);
    check({tag, "_addr"},    32'(vrf_addr_o), 0);
    check({tag, "_issued"},  32'(operand_issued_o), 0);
    check({tag, "_cmdv"},    32'(operand_queue_cmd_valid_o), 0);
    check({tag, "_cmdl"},    32'(operand_queue_cmd_len_o), 0);
    check({tag, "_done"},    32'(done_o), 0);
    check({tag, "_done_id"}, 32'(done_id_o), 0);
  endtask

  initial begin
    int c;
    int issued_seen;
    int exp_req;

    // reset
    rst_ni = 1'b0;
    idle_req();
    stall_i = 1'b0;
    vrf_gnt_i = 1'b0;
    operand_queue_ready_i = 1'b0;
    #3;
    check_all_quiet("reset");
    tick();
    tick();
    rst_ni = 1'b1;
    operand_queue_ready_i = 1'b1;
    vrf_gnt_i = 1'b1;

    // vs=2 len=3 id=5: addresses 32,33,34
    present(5'd2, 16'd3, 3'd5);
    #3;
    check("t1_acc_ready", 32'(req_ready_o), 1);
    check("t1_cmdv", 32'(operand_queue_cmd_valid_o), 1);
    check("t1_cmdl", 32'(operand_queue_cmd_len_o), 3);
    check("t1_acc_req", 32'(vrf_req_o), 0);
    tick();
    idle_req();
    for (int i = 0; i < 3; i++) begin
      #3;
      check_issue("t1", 32 + i, i == 2, 5);
      check("t1_cmdv_quiet", 32'(operand_queue_cmd_valid_o), 0);
      tick();
    end
    #3;
    check("t1_after_req", 32'(vrf_req_o), 0);
    check("t1_after_done", 32'(done_o), 0);
    tick();

    // vs=1 len=4 id=2 with stall and queue-full windows
    present(5'd1, 16'd4, 3'd2);
    #3;
    check("t2_cmdl", 32'(operand_queue_cmd_len_o), 4);
    tick();
    idle_req();
    c = 0;
    issued_seen = 0;
    for (int k = 0; k < 8 && c < 4; k++) begin
      stall_i = (k == 1 || k == 2);
      operand_queue_ready_i = !(k == 3 || k == 4);
      #3;
      exp_req = (operand_queue_ready_i && (!STALL_EN || !stall_i)) ? 1 : 0;
      check("t2_req", 32'(vrf_req_o), 32'(exp_req));
      check("t2_addr", 32'(vrf_addr_o), 32'(16 + c));
      check("t2_done", 32'(done_o), 32'((exp_req == 1) && (c == 3)));
      if (operand_issued_o) issued_seen++;
      if (exp_req == 1) c++;
      tick();
    end
    stall_i = 1'b0;
    operand_queue_ready_i = 1'b1;
    check("t2_issued_total", 32'(issued_seen), 4);
    #3;
    check("t2_idle_req", 32'(vrf_req_o), 0);
    check("t2_idle_ready", 32'(req_ready_o), 1);
    tick();

    // grant withheld: request stays up, nothing issues
    present(5'd3, 16'd1, 3'd6);
    tick();
    idle_req();
    vrf_gnt_i = 1'b0;
    #3;
    check("t3_nogrant_req", 32'(vrf_req_o), 1);
    check("t3_nogrant_issued", 32'(operand_issued_o), 0);
    check("t3_nogrant_done", 32'(done_o), 0);
    tick();
    vrf_gnt_i = 1'b1;
    #3;
    check_issue("t3", 48, 1'b1, 6);
    tick();

    // back-to-back: id1 (vs=0,len=2), id2 (vs=4,len=1) in last-grant cycle
    present(5'd0, 16'd2, 3'd1);
    tick();
    idle_req();
    #3;
    check_issue("t4a", 0, 1'b0, 1);
    tick();
    present(5'd4, 16'd1, 3'd2);
    #3;
    check_issue("t4b", 1, 1'b1, 1);
    check("t4b_cmdv", 32'(operand_queue_cmd_valid_o), 1);
    check("t4b_cmdl", 32'(operand_queue_cmd_len_o), 1);
    tick();
    idle_req();
    #3;
    check_issue("t4c", 64, 1'b1, 2);
    tick();
    #3;
    check("t4_after_done", 32'(done_o), 0);
    tick();

    // wrap: vs=31 len=18 -> 496..511, 0, 1
    present(5'd31, 16'd18, 3'd7);
    tick();
    idle_req();
    for (int i = 0; i < 18; i++) begin
      #3;
      check_issue("t5", (496 + i) % 512, i == 17, 7);
      tick();
    end

    // zero length: done one cycle later, no command, no read
    present(5'd9, 16'd0, 3'd3);
    #3;
    check("t6_cmdv", 32'(operand_queue_cmd_valid_o), 0);
    check("t6_req0", 32'(vrf_req_o), 0);
    check("t6_done0", 32'(done_o), 0);
    tick();
    idle_req();
    #3;
    check("t6_done", 32'(done_o), 1);
    check("t6_done_id", 32'(done_id_o), 3);
    check("t6_req1", 32'(vrf_req_o), 0);
    check("t6_ready", 32'(req_ready_o), 1);
    tick();
    #3;
    check("t6_done_clear", 32'(done_o), 0);
    tick();

    // reset after 2 of 5 grants
    present(5'd5, 16'd5, 3'd4);
    tick();
    idle_req();
    #3;
    check_issue("t7a", 80, 1'b0, 4);
    tick();
    #3;
    check_issue("t7b", 81, 1'b0, 4);
    tick();
    rst_ni = 1'b0;
    #3;
    check_all_quiet("t7_rst");
    tick();
    rst_ni = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #3;
      check_all_quiet("t7_post");
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Watchdog: the directed sequence is a few hundred cycles at most.
  initial begin
    #20000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
